// File: rtl/timer_sample_scheduler_if.sv
// Bus bundle between the sample scheduler, the interval timer slave and the
// sensor front-end: timer register write port plus the sample req/ack handshake.
interface timer_sample_scheduler_if #(
  parameter int CH_W = 2
);
  logic [2:0]      tmr_address;
  logic            tmr_chipselect;
  logic            tmr_write_n;
  logic [15:0]     tmr_writedata;
  logic            tmr_irq;
  logic            sample_req;
  logic [CH_W-1:0] sample_ch;
  logic            sample_ack;

  modport master (
    output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    output sample_req, sample_ch,
    input  tmr_irq, sample_ack
  );

  modport slave (
    input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    input  sample_req, sample_ch,
    output tmr_irq, sample_ack
  );
endinterface

// File: rtl/timer_sample_scheduler.sv
// Drives the interval timer over Avalon-MM and turns each timeout into a
// round-robin sample request, for a programmed burst of samples per session.
module timer_sample_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  timer_sample_scheduler_if.master  bus,
  input  logic                      enable,
  input  logic [31:0]               period,
  input  logic [7:0]                burst_len,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun,
  output logic [7:0]                sample_count
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_PL    = 4'd1,
    S_WR_PH    = 4'd2,
    S_WR_CLR   = 4'd3,
    S_WR_START = 4'd4,
    S_WAIT_IRQ = 4'd5,
    S_ACK_IRQ  = 4'd6,
    S_REQ      = 4'd7,
    S_WR_STOP  = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  localparam logic [2:0]  ADDR_STATUS  = 3'd0;
  localparam logic [2:0]  ADDR_CONTROL = 3'd1;
  localparam logic [2:0]  ADDR_PERIODL = 3'd2;
  localparam logic [2:0]  ADDR_PERIODH = 3'd3;
  localparam logic [15:0] CTRL_START   = 16'h0007;
  localparam logic [15:0] CTRL_STOP    = 16'h0008;
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(NUM_CH - 1);

  state_t          state_q,   state_d;
  logic [31:0]     period_q,  period_d;
  logic [7:0]      burst_q,   burst_d;
  logic [7:0]      count_q,   count_d;
  logic [CH_W-1:0] ch_q,      ch_d;
  logic            overrun_q, overrun_d;
  logic [2:0]      addr_q,    addr_d;
  logic            cs_q,      cs_d;
  logic            wr_n_q,    wr_n_d;
  logic [15:0]     wdata_q,   wdata_d;
  logic            req_q,     req_d;
  logic            busy_q,    busy_d;
  logic            done_q,    done_d;

  logic [7:0]      count_inc_s;
  logic [CH_W-1:0] ch_next_s;

  assign count_inc_s = count_q + 8'd1;
  assign ch_next_s   = (ch_q == CH_LAST) ? {CH_W{1'b0}} : (ch_q + {{(CH_W-1){1'b0}}, 1'b1});

  // Next-state and session bookkeeping; outputs are decoded from the next state
  // so that every output is a flop with no input-to-output combinational path.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    burst_d   = burst_q;
    count_d   = count_q;
    ch_d      = ch_q;
    overrun_d = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          period_d  = period;
          burst_d   = burst_len;
          count_d   = 8'd0;
          ch_d      = {CH_W{1'b0}};
          overrun_d = 1'b0;
          state_d   = S_WR_PL;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_WR_PL:    state_d = S_WR_PH;
      S_WR_PH:    state_d = S_WR_CLR;
      S_WR_CLR:   state_d = S_WR_START;
      S_WR_START: state_d = S_WAIT_IRQ;
      S_WAIT_IRQ: begin
        if (!enable) begin
          state_d = S_WR_STOP;
        end else if (bus.tmr_irq) begin
          state_d = S_ACK_IRQ;
        end else begin
          state_d = S_WAIT_IRQ;
        end
      end
      S_ACK_IRQ:  state_d = S_REQ;
      S_REQ: begin
        // A timeout while the sensor is still busy stays latched in the timer
        // and is serviced after the ack; only flag that the cadence slipped.
        if (bus.tmr_irq) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (bus.sample_ack) begin
          count_d = count_inc_s;
          ch_d    = ch_next_s;
          if (((burst_q != 8'd0) && (count_inc_s == burst_q)) || !enable) begin
            state_d = S_WR_STOP;
          end else begin
            state_d = S_WAIT_IRQ;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_WR_STOP:  state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    cs_d    = 1'b0;
    wr_n_d  = 1'b1;
    addr_d  = 3'd0;
    wdata_d = 16'h0000;
    case (state_d)
      S_WR_PL: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_PERIODL; wdata_d = period_d[15:0];
      end
      S_WR_PH: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_PERIODH; wdata_d = period_d[31:16];
      end
      S_WR_CLR, S_ACK_IRQ: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_STATUS; wdata_d = 16'h0000;
      end
      S_WR_START: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_CONTROL; wdata_d = CTRL_START;
      end
      S_WR_STOP: begin
        cs_d = 1'b1; wr_n_d = 1'b0; addr_d = ADDR_CONTROL; wdata_d = CTRL_STOP;
      end
      default: begin
        cs_d = 1'b0; wr_n_d = 1'b1; addr_d = 3'd0; wdata_d = 16'h0000;
      end
    endcase

    req_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, captured session parameters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      period_q  <= 32'd0;
      burst_q   <= 8'd0;
      count_q   <= 8'd0;
      ch_q      <= {CH_W{1'b0}};
      overrun_q <= 1'b0;
      addr_q    <= 3'd0;
      cs_q      <= 1'b0;
      wr_n_q    <= 1'b1;
      wdata_q   <= 16'h0000;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      burst_q   <= burst_d;
      count_q   <= count_d;
      ch_q      <= ch_d;
      overrun_q <= overrun_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      wr_n_q    <= wr_n_d;
      wdata_q   <= wdata_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.tmr_address    = addr_q;
  assign bus.tmr_chipselect = cs_q;
  assign bus.tmr_write_n    = wr_n_q;
  assign bus.tmr_writedata  = wdata_q;
  assign bus.sample_req     = req_q;
  assign bus.sample_ch      = ch_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign overrun            = overrun_q;
  assign sample_count       = count_q;

endmodule

// File: tb/tb_timer_sample_scheduler.sv
// Scoreboard bench: a small interval-timer model and sensor responder drive the
// scheduler; expected bus events are queued up front and checked by a monitor.
module tb_timer_sample_scheduler;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] period = 32'd0;
  logic [7:0]  burst_len = 8'd0;
  logic        busy, done, overrun;
  logic [7:0]  sample_count;

  timer_sample_scheduler_if #(.CH_W(CH_W)) bus ();

  timer_sample_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .enable(enable), .period(period),
    .burst_len(burst_len), .busy(busy), .done(done), .overrun(overrun),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Interval timer model: counts period..0, latches TO, irq = TO & ITO.
  logic [31:0] t_per, t_cnt;
  logic        t_run, t_ito, t_to;
  logic        tmr_fast = 1'b0;
  assign bus.tmr_irq = t_to & t_ito;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_per <= 32'd0; t_cnt <= 32'd0; t_run <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0;
    end else begin
      if (bus.tmr_chipselect && !bus.tmr_write_n) begin
        case (bus.tmr_address)
          3'd0: t_to <= 1'b0;
          3'd1: begin
            t_ito <= bus.tmr_writedata[0];
            if (bus.tmr_writedata[3]) t_run <= 1'b0;
          end
          3'd2: t_per[15:0]  <= bus.tmr_writedata;
          3'd3: t_per[31:16] <= bus.tmr_writedata;
          default: ;
        endcase
      end
      if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd1 && bus.tmr_writedata[2]) begin
        t_run <= 1'b1;
        t_cnt <= tmr_fast ? 32'd15 : t_per;
      end else if (t_run) begin
        if (t_cnt == 32'd0) begin
          t_to  <= 1'b1;
          t_cnt <= tmr_fast ? 32'd15 : t_per;
        end else begin
          t_cnt <= t_cnt - 32'd1;
        end
      end
    end
  end

  // Sensor responder: ack ack_dly cycles after seeing a request (12 if long_next).
  int   ack_dly = 2;
  int   ack_cyc = 0;
  int   sd;
  logic long_next = 1'b0;
  initial begin
    bus.sample_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.sample_req === 1'b1 && reset_n) begin
        sd = long_next ? 12 : ack_dly;
        long_next = 1'b0;
        repeat (sd) @(negedge clk);
        bus.sample_ack = 1'b1;
        ack_cyc = cyc;
        @(negedge clk);
        bus.sample_ack = 1'b0;
      end
    end
  end

  // kind: 0 timer write (a=addr, d=data), 1 request (a=channel), 2 done (a=count)
  typedef struct {
    int kind;
    int a;
    int d;
    int gap;
    int ref_ack;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_ev(input int kind, input int a, input int d, input int gap, input int ref_ack);
    exp_t e;
    e.kind = kind; e.a = a; e.d = d; e.gap = gap; e.ref_ack = ref_ack;
    exp_q.push_back(e);
  endtask

  task automatic push_cfg(input logic [31:0] p);
    push_ev(0, 2, int'(p[15:0]), -1, 0);
    push_ev(0, 3, int'(p[31:16]), -1, 0);
    push_ev(0, 0, 0, -1, 0);
    push_ev(0, 1, 7, -1, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int last_rise = 0;
  task automatic observe(input int kind, input int a, input int d);
    exp_t e;
    int   g;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected kind=%0d a=%0h d=%0h at cycle %0d", kind, a, d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.d != d) begin
        errors++;
        $display("FAIL event: got kind=%0d a=%0h d=%0h expected kind=%0d a=%0h d=%0h at cycle %0d",
                 kind, a, d, e.kind, e.a, e.d, cyc);
      end
      if (kind == 1 && e.kind == 1 && e.gap >= 0) begin
        g = e.ref_ack ? (cyc - (ack_cyc + 1)) : (cyc - last_rise);
        chk(e.ref_ack ? "req_gap_after_ack" : "req_spacing", g, e.gap);
      end
    end
    if (kind == 1) last_rise = cyc;
  endtask

  // Monitor: sample DUT outputs on the falling edge and score each event.
  logic prev_req = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_req = 1'b0;
      end else begin
        if (bus.tmr_chipselect) begin
          chk("write_n", bus.tmr_write_n, 1'b0);
          observe(0, int'(bus.tmr_address), int'(bus.tmr_writedata));
        end
        if (bus.sample_req && !prev_req) observe(1, int'(bus.sample_ch), 0);
        if (done) observe(2, int'(sample_count), 0);
        prev_req = bus.sample_req;
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_cs"},    bus.tmr_chipselect, 1'b0);
    chk({tag, "_wn"},    bus.tmr_write_n,    1'b1);
    chk({tag, "_addr"},  bus.tmr_address,    3'd0);
    chk({tag, "_wdata"}, bus.tmr_writedata,  16'h0000);
    chk({tag, "_req"},   bus.sample_req,     1'b0);
    chk({tag, "_ch"},    bus.sample_ch,      2'd0);
    chk({tag, "_busy"},  busy,               1'b0);
    chk({tag, "_done"},  done,               1'b0);
    chk({tag, "_ovr"},   overrun,            1'b0);
    chk({tag, "_count"}, sample_count,       8'd0);
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired at cycle %0d", name, cyc);
  endtask

  // Wait for the done pulse, release enable, confirm return to IDLE.
  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      timeout("done_wait");
    end else begin
      enable = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 1'b0);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (bus.sample_req !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeout("req_wait");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Burst of 3 at period 9: channels 0,1,2 ten cycles apart.
    period = 32'd9; burst_len = 8'd3; ack_dly = 2;
    push_cfg(32'd9);
    for (int i = 0; i < 3; i++) begin
      push_ev(0, 0, 0, -1, 0);
      push_ev(1, i, 0, (i == 0) ? -1 : 10, 0);
    end
    push_ev(0, 1, 8, -1, 0);
    push_ev(2, 3, 0, -1, 0);
    enable = 1'b1;
    wait_done(400);
    chk("t1_count", sample_count, 8'd3);
    chk("t1_overrun", overrun, 1'b0);
    wait_drain(5);

    // Wide period split across the two period registers, single sample.
    tmr_fast = 1'b1;
    period = 32'h0001_86A0; burst_len = 8'd1;
    push_cfg(32'h0001_86A0);
    push_ev(0, 0, 0, -1, 0);
    push_ev(1, 0, 0, -1, 0);
    push_ev(0, 1, 8, -1, 0);
    push_ev(2, 1, 0, -1, 0);
    enable = 1'b1;
    wait_done(200);
    wait_drain(5);
    tmr_fast = 1'b0;

    // Unlimited mode, drop enable in WAIT_IRQ after 6 samples (irq coincides).
    period = 32'd4; burst_len = 8'd0;
    push_cfg(32'd4);
    for (int i = 0; i < 6; i++) begin
      push_ev(0, 0, 0, -1, 0);
      push_ev(1, i % NUM_CH, 0, (i == 0) ? -1 : 5, 0);
    end
    push_ev(0, 1, 8, -1, 0);
    push_ev(2, 6, 0, -1, 0);
    enable = 1'b1;
    begin
      int n = 0;
      while (sample_count != 8'd6 && n < 400) begin
        @(negedge clk);
        n++;
      end
      if (n >= 400) timeout("count6_wait");
    end
    enable = 1'b0;
    wait_done(50);
    chk("t3_count", sample_count, 8'd6);
    wait_drain(5);

    // Slow sensor: first ack held 12 cycles -> overrun, next req 2 cycles after ack.
    period = 32'd4; burst_len = 8'd2; long_next = 1'b1;
    push_cfg(32'd4);
    push_ev(0, 0, 0, -1, 0);
    push_ev(1, 0, 0, -1, 0);
    push_ev(0, 0, 0, -1, 0);
    push_ev(1, 1, 0, 2, 1);
    push_ev(0, 1, 8, -1, 0);
    push_ev(2, 2, 0, -1, 0);
    enable = 1'b1;
    wait_done(300);
    chk("t4_overrun", overrun, 1'b1);
    chk("t4_count", sample_count, 8'd2);
    wait_drain(5);

    // Enable dropped while a request is outstanding: sample still completes.
    period = 32'd9; burst_len = 8'd0; ack_dly = 2;
    push_cfg(32'd9);
    push_ev(0, 0, 0, -1, 0);
    push_ev(1, 0, 0, -1, 0);
    push_ev(0, 1, 8, -1, 0);
    push_ev(2, 1, 0, -1, 0);
    enable = 1'b1;
    wait_req(100);
    enable = 1'b0;
    wait_done(100);
    chk("t5_count", sample_count, 8'd1);
    chk("t5_overrun", overrun, 1'b0);
    wait_drain(5);

    // Asynchronous reset during REQ, then a full reconfiguration.
    period = 32'd9; burst_len = 8'd0;
    push_cfg(32'd9);
    push_ev(0, 0, 0, -1, 0);
    push_ev(1, 0, 0, -1, 0);
    enable = 1'b1;
    wait_req(100);
    @(negedge clk);
    chk("t6_req_before_reset", bus.sample_req, 1'b1);
    wait_drain(2);
    reset_n = 1'b0;
    #1;
    check_reset("midreset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_cfg(32'd9);
    reset_n = 1'b1;
    wait_drain(20);
    enable = 1'b0;
    push_ev(0, 1, 8, -1, 0);
    push_ev(2, 0, 0, -1, 0);
    wait_done(50);
    wait_drain(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_sample_scheduler.md
# timer_sample_scheduler

Avalon-MM master that owns the 16-bit interval timer peripheral and turns its timeout interrupt into a paced stream of sensor-sample requests. It programs the timer period, starts the timer in continuous mode with interrupts enabled, services each timeout by clearing the timer status, and issues a round-robin req/ack sample request to the sensor acquisition logic. It runs for a programmed burst of samples and then stops the timer. It sits between the system timer slave and the sensor front-end, so sampling cadence needs no CPU involvement.

## Interface
- NUM_CH, 4: number of sensor channels served round-robin (2..16).
- CH_W, 2: width of sample_ch; must satisfy 2**CH_W >= NUM_CH.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; high starts/continues a session, low ends it.
- period  in  32  timer period value; one timeout every period+1 cycles. Captured at session start.
- burst_len  in  8  samples per session; 0 = unlimited. Captured at session start.
- tmr_address  out  3  timer register address (0 status, 1 control, 2 period_l, 3 period_h).
- tmr_chipselect  out  1  timer select, one cycle per write.
- tmr_write_n  out  1  active-low write strobe.
- tmr_writedata  out  16  timer write data.
- tmr_irq  in  1  timer interrupt (latched in timer until status write).
- sample_req  out  1  sample request to sensor logic.
- sample_ch  out  CH_W  channel for the current request.
- sample_ack  in  1  single-cycle completion from sensor logic.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at session end.
- overrun  out  1  sticky: timeout arrived while a request was outstanding.
- sample_count  out  8  acknowledged samples this session.

## Operation
- Moore FSM. States: IDLE, WR_PL, WR_PH, WR_CLR, WR_START, WAIT_IRQ, ACK_IRQ, REQ, WR_STOP, DONE.
- IDLE: when enable=1, capture period/burst_len, clear sample_count, sample_ch, and overrun; go to WR_PL.
- Each WR_* and ACK_IRQ state is exactly one cycle with chipselect=1 and write_n=0. The timer slave has no wait states.
  - WR_PL: addr 2, data period[15:0].
  - WR_PH: addr 3, data period[31:16].
  - WR_CLR: addr 0, data 0.
  - WR_START: addr 1, data 0x0007 (start, continuous, irq enable).
  - ACK_IRQ: addr 0, data 0.
  - WR_STOP: addr 1, data 0x0008 (stop, irq disabled).
- Outside the write states: chipselect=0, write_n=1, address=0, writedata=0.
- WAIT_IRQ:
  - enable=0 -> WR_STOP.
  - else tmr_irq=1 -> ACK_IRQ.
  - enable=0 takes priority over a simultaneous tmr_irq.
- ACK_IRQ -> REQ.
- REQ: sample_req=1 and held until sample_ack is sampled high. Sample_ch is stable throughout. Enable is ignored while a request is outstanding.
- On ack:
  - sample_count increments; it wraps 255 -> 0 in unlimited mode.
  - sample_ch advances; it wraps NUM_CH-1 -> 0.
  - If burst_len != 0 and the new count equals burst_len, or enable=0, go to WR_STOP; else go to WAIT_IRQ.
- tmr_irq=1 in any REQ cycle sets overrun. That timeout stays latched in the timer and is serviced right after the ack via WAIT_IRQ. No sample is dropped; only the cadence slips.
- WR_STOP -> DONE (done=1 for one cycle) -> IDLE. A new session needs enable high in IDLE. A still-high enable restarts immediately.
- sample_count, sample_ch, and overrun hold their values in IDLE until the next session start.

## Timing
- Reset values: tmr_chipselect 0, tmr_write_n 1, tmr_address 0, tmr_writedata 0, sample_req 0, sample_ch 0, busy 0, done 0, overrun 0, sample_count 0. State is IDLE.
- All outputs are registered or state-decoded, with no combinational path from inputs to outputs.
- enable sampled high at edge E0 → the WR_PL write occupies cycle E0+1, WR_PH E0+2, WR_CLR E0+3, and WR_START E0+4.
- tmr_irq sampled high at edge I → ACK_IRQ write in cycle I+1 → sample_req=1 from cycle I+2.
- sample_ack sampled at edge A → sample_req=0 and the updated count/channel are visible from cycle A+1.
- Final ack at edge A → WR_STOP write in cycle A+1 → done=1 in cycle A+2 → busy=0 from cycle A+3.
- The timer irq falls one cycle after the ACK_IRQ write. REQ lasts at least one cycle, so a stale irq is never re-serviced.
- Reset mid-session returns to IDLE immediately. The timer shares reset_n and returns to its reset state.

## Test plan
- period=9, burst_len=3, NUM_CH=4, ack 2 cycles after req.
  - Required writes: (2,9), (3,0), (0,0), (1,7).
  - Three requests on channels 0, 1, 2 spaced 10 cycles apart.
  - Then the (1,8) write, a done pulse, and sample_count=3.
- period=0x0001_86A0, burst_len=1: WR_PL data 0x86A0 and WR_PH data 0x0001. One sample, then stop.
- burst_len=0, period=4, enable held for 6 samples and then dropped during WAIT_IRQ.
  - Channels go 0, 1, 2, 3, 0, 1.
  - Stop write follows, done pulses, and sample_count=6.
- period=4, ack held off for 12 cycles:
  - overrun=1.
  - The next request is asserted 2 cycles after the ack.
  - sample_count stays exact.
- Assert reset_n=0 during REQ:
  - All outputs return to reset values asynchronously.
  - After release with enable=1, the full 4-write configuration sequence repeats.
- enable dropped during REQ: sample_req is held until ack, then the stop write and done follow. sample_count includes that sample.
